// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ID/EX decode/issue stage.
// Holds the RV64-subset opcode constants, the ALU operation encodings,
// the packed ID/EX entry that crosses the stage boundary, and the skid
// buffer state type. DATA_W sets the operand/PC width for every file.
package alu_ctrl_pkg;

    localparam int DATA_W = 64;

    // Major opcodes, instr[6:0]
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_IALU   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_CUSTOM = 7'b0001011;

    // funct3 values, instr[14:12]
    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_NOR = 3'b000;

    // Operation codes understood by the downstream ALU
    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_NOR = 4'b1100
    } alu_op_e;

    // Everything EX/MEM consume for one instruction
    typedef struct packed {
        logic [DATA_W-1:0] alu_a;
        logic [DATA_W-1:0] alu_b;
        logic [DATA_W-1:0] branch_target;
        alu_op_e           alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              is_branch;
        logic [4:0]        rd;
        logic              illegal;
    } id_ex_t;

    // Idle entry: an ADD with no side effects
    localparam id_ex_t ID_EX_IDLE = '{
        alu_a:         '0,
        alu_b:         '0,
        branch_target: '0,
        alu_op:        ALU_ADD,
        reg_write:     1'b0,
        mem_read:      1'b0,
        mem_write:     1'b0,
        is_branch:     1'b0,
        rd:            5'd0,
        illegal:       1'b0
    };

    // Occupancy of the two-entry skid buffer
    typedef enum logic [1:0] {
        BUF_EMPTY,
        BUF_ONE,
        BUF_TWO
    } buf_state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decoder for the supported RV64 subset.
// Produces the control part of an ID/EX entry (alu_op, write/branch
// controls, rd, illegal) plus the B-operand select; operand and target
// fields are left zero for the top level to fill in.
// Build option: define ALU_CTRL_ILLEGAL_TRAP_EN to flag unsupported
// encodings with illegal=1; otherwise they decode as a side-effect-free ADD.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output id_ex_t      ctrl_o,
    output logic        b_sel_imm_o
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_b5;
    logic       legal;
    logic       unused_instr_bits;

    assign opcode    = instr_i[6:0];
    assign funct3    = instr_i[14:12];
    assign funct7_b5 = instr_i[30];

    // Register indices and the rest of funct7 play no part in control decode
    assign unused_instr_bits = ^{instr_i[31], instr_i[29:15]};

    // Map opcode/funct fields onto ALU op, operand select and side-band controls
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a value unassigned, which would otherwise infer a latch.
        ctrl_o      = ID_EX_IDLE;
        b_sel_imm_o = 1'b1;
        legal       = 1'b1;

        case (opcode)
            OPC_RTYPE: begin
                b_sel_imm_o      = 1'b0;
                ctrl_o.reg_write = 1'b1;
                case (funct3)
                    F3_ADD:  ctrl_o.alu_op = funct7_b5 ? ALU_SUB : ALU_ADD;
                    F3_AND:  ctrl_o.alu_op = ALU_AND;
                    F3_OR:   ctrl_o.alu_op = ALU_OR;
                    default: legal = 1'b0;
                endcase
            end
            OPC_IALU: begin
                ctrl_o.reg_write = 1'b1;
                case (funct3)
                    F3_ADD:  ctrl_o.alu_op = ALU_ADD;
                    F3_AND:  ctrl_o.alu_op = ALU_AND;
                    F3_OR:   ctrl_o.alu_op = ALU_OR;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            OPC_STORE: begin
                ctrl_o.mem_write = 1'b1;
            end
            OPC_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    b_sel_imm_o      = 1'b0;
                    ctrl_o.alu_op    = ALU_SUB;
                    ctrl_o.is_branch = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            OPC_CUSTOM: begin
                if (funct3 == F3_NOR) begin
                    b_sel_imm_o      = 1'b0;
                    ctrl_o.alu_op    = ALU_NOR;
                    ctrl_o.reg_write = 1'b1;
                end else begin
                    legal = 1'b0;
                end
            end
            default: legal = 1'b0;
        endcase

        // Unsupported encodings collapse to an ADD with B = imm and no side effects
        if (!legal) begin
            ctrl_o      = ID_EX_IDLE;
            b_sel_imm_o = 1'b1;
`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
            ctrl_o.illegal = 1'b1;
`else
            ctrl_o.illegal = 1'b0;
`endif
        end

        // Instructions that do not write the register file carry rd = x0
        ctrl_o.rd = ctrl_o.reg_write ? instr_i[11:7] : 5'd0;
    end

endmodule

// File: rtl/alu_ctrl_id_ex.sv
// ID/EX boundary stage feeding the 64-bit ALU.
// Decodes the incoming instruction, forms both ALU operands and the branch
// target, and registers the result through a two-entry skid buffer with a
// valid/ready handshake. in_ready is registered from buffer occupancy so it
// never depends combinationally on out_ready. flush empties the buffer and
// drops any input offered in the same cycle; reset dominates flush.
// Build option: ALU_CTRL_ILLEGAL_TRAP_EN (see alu_ctrl_decode).
module alu_ctrl_id_ex
    import alu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs1_data,
    input  logic [DATA_W-1:0] rs2_data,
    input  logic [DATA_W-1:0] imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    output logic              reg_write,
    output logic              mem_read,
    output logic              mem_write,
    output logic              is_branch,
    output logic [4:0]        rd,
    output logic [DATA_W-1:0] branch_target,
    output logic              illegal
);

    id_ex_t     dec_ctrl;
    logic       b_sel_imm;
    id_ex_t     entry_d;

    buf_state_e state_q;
    id_ex_t     head_q;
    id_ex_t     skid_q;
    logic       in_ready_q;
    logic       out_valid_q;

    logic       accept;
    logic       drain;
    logic       skid_load;

    alu_ctrl_decode u_decode (
        .instr_i     (instr),
        .ctrl_o      (dec_ctrl),
        .b_sel_imm_o (b_sel_imm)
    );

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    // Complete the decoded entry with operands and the wrapping branch target
    always_comb begin
        entry_d               = dec_ctrl;
        entry_d.alu_a         = rs1_data;
        entry_d.alu_b         = b_sel_imm ? imm : rs2_data;
        entry_d.branch_target = pc + imm;
    end

    // Buffer occupancy FSM with registered handshake outputs and head entry
    always_ff @(posedge clk) begin
        // NOTE: all state in clocked blocks uses non-blocking assignment so
        // every register samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= BUF_EMPTY;
            head_q      <= ID_EX_IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            state_q     <= BUF_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (accept) begin
                        head_q      <= entry_d;
                        state_q     <= BUF_ONE;
                        out_valid_q <= 1'b1;
                    end
                end
                BUF_ONE: begin
                    if (accept && !drain) begin
                        state_q    <= BUF_TWO;
                        in_ready_q <= 1'b0;
                    end else if (accept && drain) begin
                        head_q <= entry_d;
                    end else if (drain) begin
                        state_q     <= BUF_EMPTY;
                        out_valid_q <= 1'b0;
                    end
                end
                BUF_TWO: begin
                    if (drain) begin
                        head_q     <= skid_q;
                        state_q    <= BUF_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= BUF_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // A new entry parks in the skid slot when the head is stalled
    assign skid_load = !reset && !flush && (state_q == BUF_ONE) && accept && !drain;

    // Skid entry storage, loaded only when the head cannot advance
    always_ff @(posedge clk) begin
        // NOTE: the skid slot is pure data guarded by state_q, so it carries
        // no reset; its contents are never observed while the state says empty.
        if (skid_load) begin
            skid_q <= entry_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign out_valid     = out_valid_q;
    assign alu_a         = head_q.alu_a;
    assign alu_b         = head_q.alu_b;
    assign alu_op        = head_q.alu_op;
    assign reg_write     = head_q.reg_write;
    assign mem_read      = head_q.mem_read;
    assign mem_write     = head_q.mem_write;
    assign is_branch     = head_q.is_branch;
    assign rd            = head_q.rd;
    assign branch_target = head_q.branch_target;
    assign illegal       = head_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_id_ex.sv
// Scoreboard bench for alu_ctrl_id_ex: directed instructions push their
// hand-computed expected entries into a queue; a monitor pops and compares
// each entry as EX accepts it. Direct checks cover reset, handshake
// back-pressure, flush and reset-while-busy.
module tb_alu_ctrl_id_ex;
    import alu_ctrl_pkg::*;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [3:0]        alu_op;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              is_branch;
    logic [4:0]        rd;
    logic [DATA_W-1:0] branch_target;
    logic              illegal;

    int     checks = 0;
    int     errors = 0;
    id_ex_t exp_q[$];
    id_ex_t act;

`ifdef ALU_CTRL_ILLEGAL_TRAP_EN
    localparam logic EXP_ILL = 1'b1;
`else
    localparam logic EXP_ILL = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_ctrl_id_ex dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instr         (instr),
        .pc            (pc),
        .rs1_data      (rs1_data),
        .rs2_data      (rs2_data),
        .imm           (imm),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_op        (alu_op),
        .reg_write     (reg_write),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .is_branch     (is_branch),
        .rd            (rd),
        .branch_target (branch_target),
        .illegal       (illegal)
    );

    always_comb begin
        act = '{alu_a: alu_a, alu_b: alu_b, branch_target: branch_target,
                alu_op: alu_op_e'(alu_op), reg_write: reg_write, mem_read: mem_read,
                mem_write: mem_write, is_branch: is_branch, rd: rd, illegal: illegal};
    end

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic id_ex_t mk(input alu_op_e op, input logic [63:0] a, input logic [63:0] b,
                                  input logic [63:0] bt, input logic rw, input logic mr,
                                  input logic mw, input logic br, input logic [4:0] rdv,
                                  input logic ill);
        id_ex_t e;
        e.alu_a         = a;
        e.alu_b         = b;
        e.branch_target = bt;
        e.alu_op        = op;
        e.reg_write     = rw;
        e.mem_read      = mr;
        e.mem_write     = mw;
        e.is_branch     = br;
        e.rd            = rdv;
        e.illegal       = ill;
        return e;
    endfunction

    // Offer one instruction for a single cycle; queue its expectation if it should emerge
    task automatic issue(input logic [31:0] ins, input logic [63:0] pcv, input logic [63:0] r1,
                         input logic [63:0] r2, input logic [63:0] immv,
                         input bit push, input id_ex_t e);
        instr    = ins;
        pc       = pcv;
        rs1_data = r1;
        rs2_data = r2;
        imm      = immv;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: compare every entry EX accepts against the scoreboard head
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no output", act);
                end else begin
                    check("scoreboard", act, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = '0;
        pc        = '0;
        rs1_data  = '0;
        rs2_data  = '0;
        imm       = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_entry", act, mk(ALU_ADD, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;

        // ADD x3,x1,x2 with one-cycle latency
        issue(32'h002081B3, 64'h10, 64'd5, 64'd7, 64'h44, 1,
              mk(ALU_ADD, 64'd5, 64'd7, 64'h54, 1, 0, 0, 0, 5'd3, 0));
        @(negedge clk);
        check("add_latency_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;

        // SUB then BEQ (rd field nonzero in encoding but forced to x0)
        issue(32'h402081B3, 64'h14, 64'd10, 64'd3, 64'h0, 1,
              mk(ALU_SUB, 64'd10, 64'd3, 64'h14, 1, 0, 0, 0, 5'd3, 0));
        issue(32'h00208163, 64'h100, 64'd9, 64'd9, 64'h20, 1,
              mk(ALU_SUB, 64'd9, 64'd9, 64'h120, 0, 0, 0, 1, 5'd0, 0));

        // Back-to-back stream: AND, OR, NOR, ANDI, ORI, then an unsupported opcode
        issue(32'h0020F1B3, 64'h0, 64'hF0F0, 64'hFF00, 64'h0, 1,
              mk(ALU_AND, 64'hF0F0, 64'hFF00, 64'h0, 1, 0, 0, 0, 5'd3, 0));
        issue(32'h0020E1B3, 64'h0, 64'hF0F0, 64'hFF00, 64'h0, 1,
              mk(ALU_OR, 64'hF0F0, 64'hFF00, 64'h0, 1, 0, 0, 0, 5'd3, 0));
        issue(32'h0020830B, 64'h0, 64'h1, 64'h2, 64'h0, 1,
              mk(ALU_NOR, 64'h1, 64'h2, 64'h0, 1, 0, 0, 0, 5'd6, 0));
        issue(32'h00F0F213, 64'h0, 64'h1234, 64'h5555, 64'hF, 1,
              mk(ALU_AND, 64'h1234, 64'hF, 64'hF, 1, 0, 0, 0, 5'd4, 0));
        check("stream_in_ready", in_ready, 1'b1);
        issue(32'h00F0E213, 64'h0, 64'h1234, 64'h5555, 64'hF, 1,
              mk(ALU_OR, 64'h1234, 64'hF, 64'hF, 1, 0, 0, 0, 5'd4, 0));
        issue(32'h0000037F, 64'hFFFF_FFFF_FFFF_FFF0, 64'h11, 64'h33, 64'h20, 1,
              mk(ALU_ADD, 64'h11, 64'h20, 64'h10, 0, 0, 0, 0, 5'd0, EXP_ILL));
        repeat (3) @(posedge clk);
        #1;

        // LW then SW against a stalled EX: buffer fills, head holds the LW
        out_ready = 1'b0;
        issue(32'h0080A283, 64'h200, 64'h1000, 64'hDEAD, 64'h8, 1,
              mk(ALU_ADD, 64'h1000, 64'h8, 64'h208, 1, 1, 0, 0, 5'd5, 0));
        check("in_ready_after_1st", in_ready, 1'b1);
        issue(32'h0020A823, 64'h204, 64'h2000, 64'hBEEF, 64'h10, 1,
              mk(ALU_ADD, 64'h2000, 64'h10, 64'h214, 0, 0, 1, 0, 5'd0, 0));
        check("in_ready_after_2nd", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_head_valid", out_valid, 1'b1);
        check("stall_head_mem_read", mem_read, 1'b1);
        check("stall_head_alu_b", alu_b, 64'h8);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("drained_in_ready", in_ready, 1'b1);

        // Flush while TWO with a new input offered: nothing survives
        out_ready = 1'b0;
        issue(32'h00F0E213, 64'h0, 64'h1, 64'h2, 64'h3, 0, ID_EX_IDLE);
        issue(32'h00F0F213, 64'h0, 64'h4, 64'h5, 64'h6, 0, ID_EX_IDLE);
        check("two_in_ready", in_ready, 1'b0);
        flush    = 1'b1;
        instr    = 32'h002081B3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Flush while ONE with an acceptable input offered: it is dropped
        out_ready = 1'b0;
        issue(32'h0020E1B3, 64'h0, 64'h7, 64'h8, 64'h0, 0, ID_EX_IDLE);
        flush    = 1'b1;
        instr    = 32'h0020F1B3;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush_one_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset while ONE discards the entry and restores idle outputs
        out_ready = 1'b0;
        issue(32'h002081B3, 64'h40, 64'h99, 64'h77, 64'h0, 0, ID_EX_IDLE);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_one_out_valid", out_valid, 1'b0);
        check("rst_one_alu_op", alu_op, 4'b0010);
        check("rst_one_in_ready", in_ready, 1'b1);
        check("rst_one_alu_a", alu_a, 64'h0);
        @(posedge clk);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_id_ex.md
# alu_ctrl_id_ex

Decode/issue stage that sits upstream of the 64-bit ALU and produces everything the ALU consumes: the 4-bit ALU operation code, both operands, and the side-band control for the EX/MEM stages. It decodes the RV64 subset the ALU supports, registers results through a 2-entry skid buffer with a valid/ready handshake, and supports pipeline flush. It is the ID/EX boundary of the pipeline.

## Interface
- `DATA_W`, 64, operand/PC width
- `clk` in 1, rising-edge clock
- `reset` in 1, synchronous, active-high
- `flush` in 1, discard all buffered entries (branch mispredict)
- `in_valid` in 1, decode inputs valid
- `in_ready` out 1, stage can accept; registered
- `instr` in 32, instruction word
- `pc` in DATA_W, instruction address
- `rs1_data`, `rs2_data` in DATA_W, register-file reads
- `imm` in DATA_W, sign-extended immediate from the immediate generator
- `out_valid` out 1, head entry valid
- `out_ready` in 1, EX accepts head entry
- `alu_a`, `alu_b` out DATA_W, ALU operands
- `alu_op` out 4, 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
- `reg_write`, `mem_read`, `mem_write`, `is_branch` out 1, control
- `rd` out 5, destination register
- `branch_target` out DATA_W, pc + imm (wraps mod 2^DATA_W)
- `illegal` out 1, head entry is an unsupported encoding

## Operation
- Decode on opcode = instr[6:0], funct3 = [14:12], funct7[5] = [30]:
  - 0110011, R-type: f3 000 ADD, or SUB if f7[5]=1; f3 111 AND; f3 110 OR. B = rs2. reg_write=1.
  - 0010011, I-ALU: f3 000 ADD, 111 AND, 110 OR. B = imm. reg_write=1.
  - 0000011, load: ADD, B = imm, mem_read=1, reg_write=1.
  - 0100011, store: ADD, B = imm, mem_write=1.
  - 1100011 with f3 000, BEQ: SUB, B = rs2, is_branch=1. EX uses the ALU zero flag.
  - 0001011 with f3 000, custom NOR: NOR, B = rs2, reg_write=1.
  - Anything else is illegal; handling is set under Configuration.
- A = rs1_data always. rd = instr[11:7], forced to 0 when reg_write=0.
- Buffer states are EMPTY, ONE, and TWO (head + skid):
  - EMPTY to ONE on accept.
  - ONE to TWO on accept without drain.
  - ONE to EMPTY on drain without accept.
  - TWO to ONE on drain. In TWO, the skid entry moves to head.
- accept = in_valid & in_ready. drain = out_valid & out_ready.
- in_ready = (state != TWO), registered. It must not depend combinationally on out_ready.
- Entries leave in order. The head is stable while out_valid=1 and out_ready=0.
- flush takes priority over accept and drain in the same cycle. The next state is EMPTY, and an input presented that cycle is dropped.

## Timing
- Decode to output latency is 1 cycle from accept when EMPTY.
- Throughput is 1 per cycle with out_ready held high.
- Reset values: out_valid=0, in_ready=1, and all control outputs 0. alu_op=0010, alu_a/alu_b/branch_target/rd=0, illegal=0.
- Reset mid-transfer discards both entries. No output is produced for in-flight inputs.
- flush and reset together behave as reset.

## Configuration
- `ALU_CTRL_ILLEGAL_TRAP_EN`
  - Defined: an illegal encoding is buffered with illegal=1, alu_op=0010, and all write/branch controls forced to 0.
  - Undefined: illegal is tied to 0. Unsupported encodings decode as ADD with B = imm and all write/branch controls 0, so they act as a NOP.

## Structure
- Shared package `alu_ctrl_pkg`:
  - opcode constants and ALU op constants (AND/OR/ADD/SUB/NOR)
  - packed `id_ex_t` struct of all output fields
- Sub-module `alu_ctrl_decode`: purely combinational, instr in, partial `id_ex_t` out.
- The top level holds the skid buffer and operand muxes.

## Test plan
- ADD x3,x1,x2 (0x002081B3) with rs1=5, rs2=7, out_ready=1 -> next cycle out_valid=1, alu_op=0010, A=5, B=7, rd=3, reg_write=1.
- SUB (0x402081B3), then BEQ with pc=0x100 and imm=0x20 -> alu_op=0110 for both. For the BEQ: is_branch=1, branch_target=0x120, rd=0.
- Back-to-back LW then SW with out_ready=0 -> in_ready drops after the 2nd accept. The head holds the LW (mem_read=1, B=imm). Raising out_ready drains the LW, then the SW, in order.
- Buffer in TWO with flush and in_valid both asserted -> next cycle out_valid=0, in_ready=1, and the flushed input never appears.
- Opcode 0x7F:
  - macro defined -> illegal=1, reg_write=0.
  - macro undefined -> illegal=0, alu_op=0010, no writes.
- reset asserted while in state ONE -> next cycle out_valid=0, alu_op=0010, in_ready=1.
